// File: rtl/prio_rr_arbiter_pkg.sv
// Shared definitions for the priority round-robin arbiter.
//   arb_state_e : FSM state encoding (IDLE / LOCKED)
//   arb_width() : bit width for n values, never below 1
//   ARB_PRIO_W  : priority field width for the default level count
package prio_rr_arbiter_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Width in bits for n distinct values. A single value still needs one bit.
  function automatic int arb_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int ARB_PRIO_NB_DEFAULT = 4;
  localparam int ARB_PRIO_W          = arb_width(ARB_PRIO_NB_DEFAULT);

endpackage

// File: rtl/prio_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
//   master modport : requester side, drives en/req/req_prio/done
//   slave modport  : arbiter side, drives grant/grant_valid/grant_idx/state
// Handshake: a requester holds req[i] high until grant[i] is seen; the holder
// keeps the grant until it pulses done for one cycle. Grant is registered, so
// grant changes only on a rising clock edge. state is a debug view of the FSM.
interface prio_rr_arbiter_if
  import prio_rr_arbiter_pkg::*;
#(
  parameter int REQ_NB  = 4,
  parameter int PRIO_NB = 4
) ();

  localparam int PRIO_W = arb_width(PRIO_NB);
  localparam int IDX_W  = arb_width(REQ_NB);

  logic                     en;
  logic [REQ_NB-1:0]        req;
  logic [REQ_NB*PRIO_W-1:0] req_prio;
  logic                     done;
  logic [REQ_NB-1:0]        grant;
  logic                     grant_valid;
  logic [IDX_W-1:0]         grant_idx;
  logic [0:0]               state;

  modport master (
    output en, req, req_prio, done,
    input  grant, grant_valid, grant_idx, state
  );

  modport slave (
    input  en, req, req_prio, done,
    output grant, grant_valid, grant_idx, state
  );

endinterface

// File: rtl/prio_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req_vec_i   : candidate vector
//   ptr_i       : index of the last winner; search starts at ptr_i+1, cyclic
//   sel_o       : one-hot winner
//   sel_idx_o   : winner index
//   sel_valid_o : any candidate present
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_vec_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] sel_o,
  output logic [W-1:0] sel_idx_o,
  output logic         sel_valid_o
);

  int cand;

  always_comb begin
    sel_o       = '0;
    sel_idx_o   = '0;
    sel_valid_o = 1'b0;
    cand        = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr_i) + k) % N;
      if (!sel_valid_o && req_vec_i[cand]) begin
        sel_o[cand] = 1'b1;
        sel_idx_o   = W'(cand);
        sel_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_rr_arbiter.sv
// prio_rr_arbiter: N-requester arbiter with run-time priority levels and
// round-robin inside each level. The grant is registered and held until the
// holder pulses done; on done the next winner is loaded in the same cycle.
//   aclk, srst : clock and synchronous active-high reset
//   bus        : prio_rr_arbiter_if slave modport (en, req, req_prio, done in;
//                grant, grant_valid, grant_idx, state out)
// Optional build macro ARB_AGING_EN: per-requester wait counters; a requester
// that waited AGE_MAX cycles is promoted to the top priority level.
module prio_rr_arbiter
  import prio_rr_arbiter_pkg::*;
#(
  parameter int REQ_NB  = 4,
  parameter int PRIO_NB = 4,
  parameter int AGE_MAX = 15
) (
  input  logic               aclk,
  input  logic               srst,
  prio_rr_arbiter_if.slave   bus
);

  localparam int PRIO_W = arb_width(PRIO_NB);
  localparam int IDX_W  = arb_width(REQ_NB);

  localparam logic [0:0] ST_IDLE   = 1'(ARB_IDLE);
  localparam logic [0:0] ST_LOCKED = 1'(ARB_LOCKED);

  localparam logic [PRIO_W-1:0] TOP_LVL = PRIO_W'(PRIO_NB - 1);

  logic [0:0]        state_q, state_d;
  logic [REQ_NB-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PRIO_W-1:0] lvl_q, lvl_d;      // level the current grant was won at
  logic [IDX_W-1:0]  ptr_q [PRIO_NB];   // last released winner per level

  logic [PRIO_W-1:0] eff_prio [REQ_NB];
  logic [PRIO_W-1:0] max_lvl;
  logic [REQ_NB-1:0] lvl_req;
  logic [IDX_W-1:0]  pick_ptr;
  logic [REQ_NB-1:0] pick_sel;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic              release_now;
  logic              arb_now;

`ifdef ARB_AGING_EN
  localparam int AGE_W = arb_width(AGE_MAX + 1);
  logic [AGE_W-1:0] age_q [REQ_NB];
`endif

  // Effective priority: clamp out-of-range levels, then apply promotion.
  always_comb begin
    for (int i = 0; i < REQ_NB; i++) begin
      if (int'(bus.req_prio[i*PRIO_W +: PRIO_W]) >= PRIO_NB)
        eff_prio[i] = TOP_LVL;
      else
        eff_prio[i] = bus.req_prio[i*PRIO_W +: PRIO_W];
`ifdef ARB_AGING_EN
      if (age_q[i] == AGE_W'(AGE_MAX))
        eff_prio[i] = TOP_LVL;
`endif
    end
  end

  // Highest level among asserted requests, then the requests at that level.
  always_comb begin
    max_lvl = '0;
    for (int i = 0; i < REQ_NB; i++) begin
      if (bus.req[i] && (eff_prio[i] > max_lvl))
        max_lvl = eff_prio[i];
    end
    for (int i = 0; i < REQ_NB; i++) begin
      lvl_req[i] = bus.req[i] && (eff_prio[i] == max_lvl);
    end
  end

  assign release_now = (state_q == ST_LOCKED) && bus.done;
  assign arb_now     = (state_q == ST_IDLE) || release_now;

  // A release updates the pointer of its level this cycle; the same-cycle
  // re-arbitration must already see that new pointer.
  assign pick_ptr = (release_now && (lvl_q == max_lvl)) ? idx_q : ptr_q[max_lvl];

  rr_pick #(
    .N (REQ_NB),
    .W (IDX_W)
  ) u_rr_pick (
    .req_vec_i   (lvl_req),
    .ptr_i       (pick_ptr),
    .sel_o       (pick_sel),
    .sel_idx_o   (pick_idx),
    .sel_valid_o (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    lvl_d   = lvl_q;
    if (arb_now) begin
      if (bus.en && pick_valid) begin
        grant_d = pick_sel;
        idx_d   = pick_idx;
        lvl_d   = max_lvl;
        state_d = ST_LOCKED;
      end else begin
        grant_d = '0;
        idx_d   = '0;
        lvl_d   = '0;
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      lvl_q   <= '0;
      for (int l = 0; l < PRIO_NB; l++) begin
        ptr_q[l] <= IDX_W'(REQ_NB - 1);
      end
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      lvl_q   <= lvl_d;
      if (release_now)
        ptr_q[lvl_q] <= idx_q;
    end
  end

`ifdef ARB_AGING_EN
  // Count waiting cycles; holder, fresh winner and idle requesters reset.
  always_ff @(posedge aclk) begin
    if (srst) begin
      for (int i = 0; i < REQ_NB; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REQ_NB; i++) begin
        if (!bus.req[i] || grant_q[i] || (arb_now && bus.en && pick_sel[i]))
          age_q[i] <= '0;
        else if (age_q[i] != AGE_W'(AGE_MAX))
          age_q[i] <= age_q[i] + 1'b1;
      end
    end
  end
`endif

  assign bus.grant       = grant_q;
  assign bus.grant_valid = |grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// Testbench for prio_rr_arbiter (REQ_NB=4, PRIO_NB=4, AGE_MAX=8).
// Directed scenarios with literal expectations, then randomized traffic, all
// compared every cycle against a behavioural model. Honors ARB_AGING_EN.
module tb_prio_rr_arbiter;

  localparam int N       = 4;
  localparam int NLVL    = 4;
  localparam int AGE_MAX = 8;

  logic aclk;
  logic srst;

  prio_rr_arbiter_if #(.REQ_NB(N), .PRIO_NB(NLVL)) bus ();

  prio_rr_arbiter #(
    .REQ_NB  (N),
    .PRIO_NB (NLVL),
    .AGE_MAX (AGE_MAX)
  ) dut (
    .aclk (aclk),
    .srst (srst),
    .bus  (bus)
  );

  // ---------------- clock ----------------
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [6:0] exp_q[$];   // {valid, idx[1:0], grant[3:0]}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_holder;        // -1 when nothing granted
  int m_lvl;
  int m_ptr [NLVL];
  int m_age [N];

  function automatic int eff_of(input int i);
    int p;
    p = int'(bus.req_prio[i*2 +: 2]);
    if (p >= NLVL) p = NLVL - 1;
`ifdef ARB_AGING_EN
    if (m_age[i] >= AGE_MAX) p = NLVL - 1;
`endif
    return p;
  endfunction

  task automatic model_reset();
    m_holder = -1;
    m_lvl    = 0;
    for (int l = 0; l < NLVL; l++) m_ptr[l] = N - 1;
    for (int i = 0; i < N; i++) m_age[i] = 0;
  endtask

  task automatic model_step();
    int old_h, win, top, c;
    bit may_arb;
    logic [6:0] e;
    if (srst) begin
      model_reset();
    end else begin
      old_h   = m_holder;
      win     = -1;
      may_arb = (old_h < 0) || bus.done;
      if (old_h >= 0 && bus.done) m_ptr[m_lvl] = old_h;
      if (may_arb) begin
        if (bus.en && (bus.req != 0)) begin
          top = 0;
          for (int i = 0; i < N; i++)
            if (bus.req[i] && eff_of(i) > top) top = eff_of(i);
          for (int k = 1; k <= N; k++) begin
            c = (m_ptr[top] + k) % N;
            if (win < 0 && bus.req[c] && eff_of(c) == top) win = c;
          end
          m_holder = win;
          m_lvl    = top;
        end else begin
          m_holder = -1;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i] || i == old_h || i == win) m_age[i] = 0;
        else if (m_age[i] < AGE_MAX) m_age[i]++;
      end
    end
    if (m_holder >= 0) e = {1'b1, 2'(m_holder), 4'(1 << m_holder)};
    else               e = 7'd0;
    exp_q.push_back(e);
  endtask

  // One clock: model predicts, DUT clocks, outputs compared at negedge.
  task automatic cycle();
    logic [6:0] e;
    model_step();
    @(posedge aclk);
    @(negedge aclk);
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("grant",       32'(bus.grant),       32'(e[3:0]));
      check("grant_valid", 32'(bus.grant_valid), 32'(e[6]));
      check("grant_idx",   32'(bus.grant_idx),   32'(e[5:4]));
    end
  endtask

  // ---------------- stimulus ----------------
  int r0_grants;

  initial begin
    srst         = 1'b1;
    bus.en       = 1'b1;
    bus.req      = 4'hF;
    bus.req_prio = 8'h00;
    bus.done     = 1'b0;
    model_reset();

    // Reset held with all requesting: no grant.
    repeat (3) cycle();
    check("reset_grant", 32'(bus.grant), 32'h0);
    check("reset_idx",   32'(bus.grant_idx), 32'h0);

    // First grant one edge after reset release goes to req0.
    srst = 1'b0;
    cycle();
    check("first_grant", 32'(bus.grant), 32'h1);

    // Equal priorities: round-robin with no idle cycle between grants.
    bus.done = 1'b1;
    cycle(); check("rr_1", 32'(bus.grant), 32'h2);
    cycle(); check("rr_2", 32'(bus.grant), 32'h4);
    cycle(); check("rr_3", 32'(bus.grant), 32'h8);
    cycle(); check("rr_4", 32'(bus.grant), 32'h1);

    // req3 at level 3 wins every re-grant; then level 1 (req0) wins.
    bus.req_prio = {2'd3, 2'd0, 2'd0, 2'd1};
    cycle(); check("hi_1", 32'(bus.grant), 32'h8);
    cycle(); check("hi_2", 32'(bus.grant), 32'h8);
    cycle(); check("hi_3", 32'(bus.grant), 32'h8);
    bus.req = 4'b0111;
    cycle(); check("hi_drop", 32'(bus.grant), 32'h1);

    // Grant 0010 is held across request/priority changes until done.
    bus.req      = 4'hF;
    bus.req_prio = 8'h00;
    cycle(); check("lock_get", 32'(bus.grant), 32'h2);
    bus.done     = 1'b0;
    bus.req      = 4'b1101;
    bus.req_prio = {2'd3, 2'd0, 2'd0, 2'd0};
    cycle(); check("lock_hold1", 32'(bus.grant), 32'h2);
    cycle(); check("lock_hold2", 32'(bus.grant), 32'h2);
    bus.done = 1'b1;
    cycle(); check("lock_next", 32'(bus.grant), 32'h8);

    // Reset during a held grant drops it and restarts the rotation.
    bus.req      = 4'b0100;
    bus.req_prio = 8'h00;
    cycle(); check("pre_srst", 32'(bus.grant), 32'h4);
    bus.done = 1'b0;
    bus.req  = 4'hF;
    srst     = 1'b1;
    cycle(); check("srst_drop", 32'(bus.grant), 32'h0);
    srst = 1'b0;
    cycle(); check("srst_restart", 32'(bus.grant), 32'h1);

    // Low-priority req0 against permanent req3 at the top level.
    bus.req      = 4'b1001;
    bus.req_prio = {2'd3, 2'd0, 2'd0, 2'd0};
    bus.done     = 1'b1;
    r0_grants    = 0;
`ifdef ARB_AGING_EN
    for (int g = 0; g < 10; g++) begin
      cycle();
      if (bus.grant == 4'b0001) r0_grants++;
    end
    check("aging_r0_granted", 32'(r0_grants > 0), 32'd1);
`else
    for (int g = 0; g < 50; g++) begin
      cycle();
      if (bus.grant == 4'b0001) r0_grants++;
    end
    check("starve_r0_count", 32'(r0_grants), 32'd0);
`endif

    // Done in IDLE is ignored (nothing requests, then requests with done low).
    bus.req  = 4'h0;
    bus.done = 1'b1;
    cycle(); check("idle_empty", 32'(bus.grant_valid), 32'd0);
    bus.done = 1'b0;
    bus.en   = 1'b0;
    bus.req  = 4'hF;
    cycle(); check("en_low", 32'(bus.grant_valid), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      srst         = ($urandom_range(0, 63) == 0);
      bus.en       = ($urandom_range(0, 3) != 0);
      bus.req      = 4'($urandom_range(0, 15));
      bus.req_prio = 8'($urandom_range(0, 255));
      bus.done     = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
